// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: func3 codes,
// FSM states and access-size / load-extension helpers.
package mem_resp_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, SPLIT} state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        logic [2:0] n;
        case (f3)
            F3_B, F3_BU: n = 3'd1;
            F3_H, F3_HU: n = 3'd2;
            default:     n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic load_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] b,
                                             input logic [2:0]  f3);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {{24{b[7]}}, b[7:0]};
            F3_BU:   r = {24'h0, b[7:0]};
            F3_H:    r = {{16{b[15]}}, b[15:0]};
            F3_HU:   r = {16'h0, b[15:0]};
            default: r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational byte-lane steering for one array beat.
// Ports: offset/size/second select the lanes of the current beat,
// word is the array word, wd the store data; outputs byte enables,
// merged write word and read bytes rotated to access position.
module dmem_lane_steer (
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic        second,
    input  logic [31:0] word,
    input  logic [31:0] wd,
    output logic [3:0]  be,
    output logic [31:0] wmerge,
    output logic [31:0] rbytes
);

    logic [7:0]  smask;
    logic [7:0]  mask8;
    logic [4:0]  sh;
    logic [63:0] wsh;
    logic [31:0] wbeat;

    // The access is viewed as a window over two consecutive words;
    // beat 1 uses the low word half, beat 2 the high half.
    always_comb begin
        sh = {offset, 3'b000};
        unique case (1'b1)
            (size == 3'd1): smask = 8'h01;
            (size == 3'd2): smask = 8'h03;
            default:        smask = 8'h0F;
        endcase
        mask8 = smask << offset;
        wsh   = {32'h0, wd} << sh;
        be    = second ? mask8[7:4] : mask8[3:0];
        wbeat = second ? wsh[63:32] : wsh[31:0];
        for (int i = 0; i < 4; i++) begin
            wmerge[8*i +: 8] = be[i] ? wbeat[8*i +: 8] : word[8*i +: 8];
        end
        // Second beat places high-word bytes above the 4-offset bytes
        // already taken from the low word.
        rbytes = second ? (word << (6'd32 - {1'b0, sh}))
                        : (word >> sh);
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: lane steering, store merge, load
// extension, two-beat split of word-crossing accesses.
// Ports: clk, reset (sync, active-high), MemRead, MemWrite, addr, wd,
// func3 in; rd_data, rd_valid, busy, err out (all registered).
module dmem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int IW    = DM_ADDRESS - 2;
    localparam int DEPTH = 2 ** IW;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t          state;
    logic [IW-1:0]   h_idx;
    logic [1:0]      h_off;
    logic [2:0]      h_f3;
    logic            h_store;
    logic [31:0]     h_wd;
    logic [31:0]     h_part;

    logic            req;
    logic            legal;
    logic            split;
    logic            second;
    logic            mem_we;
    logic [IW-1:0]   cur_idx;
    logic [1:0]      cur_off;
    logic [2:0]      cur_f3;
    logic [31:0]     cur_wd;
    logic [31:0]     word;
    logic [3:0]      be;
    logic [31:0]     wmerge;
    logic [31:0]     rbytes;

    always_comb begin
        req    = MemRead | MemWrite;
        legal  = MemWrite ? store_legal(func3) : load_legal(func3);
        split  = ({1'b0, addr[1:0]} + size_bytes(func3)) > 3'd4;
        second = (state == SPLIT);
        // Word index wraps naturally at the top of the array.
        cur_idx = second ? h_idx + IW'(1) : addr[DM_ADDRESS-1:2];
        cur_off = second ? h_off : addr[1:0];
        cur_f3  = second ? h_f3  : func3;
        cur_wd  = second ? h_wd  : wd;
        word    = mem[cur_idx];
        // Reset cancels any beat, including a pending second one.
        mem_we  = !reset &&
                  (second ? h_store : (req && MemWrite && legal));
    end

    dmem_lane_steer u_steer (
        .offset (cur_off),
        .size   (size_bytes(cur_f3)),
        .second (second),
        .word   (word),
        .wd     (cur_wd),
        .be     (be),
        .wmerge (wmerge),
        .rbytes (rbytes)
    );

    always_ff @(posedge clk) begin
        if (mem_we && (be != 4'h0)) begin
            mem[cur_idx] <= wmerge;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            h_idx    <= '0;
            h_off    <= '0;
            h_f3     <= '0;
            h_store  <= 1'b0;
            h_wd     <= '0;
            h_part   <= '0;
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
            if (state == SPLIT) begin
                state <= IDLE;
                busy  <= 1'b0;
                if (!h_store) begin
                    rd_data  <= load_ext(h_part | rbytes, h_f3);
                    rd_valid <= 1'b1;
                end
            end else if (req) begin
                if (!legal) begin
                    err <= 1'b1;
                end else if (split) begin
                    state   <= SPLIT;
                    busy    <= 1'b1;
                    h_idx   <= addr[DM_ADDRESS-1:2];
                    h_off   <= addr[1:0];
                    h_f3    <= func3;
                    h_store <= MemWrite;
                    h_wd    <= wd;
                    h_part  <= rbytes;
                end else if (!MemWrite) begin
                    rd_data  <= load_ext(rbytes, func3);
                    rd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-array reference model,
// per-cycle output compare, directed cases plus random traffic.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic [2:0]  func3;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        err;

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(9)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .addr     (addr),
        .wd       (wd),
        .func3    (func3),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [7:0]  ref_mem [512];
    logic        e_busy  = 1'b0;
    logic        e_valid = 1'b0;
    logic        e_err   = 1'b0;
    logic        e_chkd  = 1'b0;
    logic [31:0] e_data  = 32'h0;
    logic        chk_en  = 1'b0;
    logic [31:0] last_rd = 32'h0;
    int          n_chk   = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'h0, busy}, {31'h0, e_busy});
            chk("rd_valid", {31'h0, rd_valid}, {31'h0, e_valid});
            chk("err", {31'h0, err}, {31'h0, e_err});
            if (e_chkd) chk("rd_data", rd_data, e_data);
            if (rd_valid) last_rd = rd_data;
        end
    end

    function automatic logic [31:0] model_load(input logic [8:0] a,
                                               input logic [2:0] f3);
        int n;
        logic [31:0] v;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        v = 32'h0;
        for (int k = 0; k < n; k++)
            v[8*k +: 8] = ref_mem[(int'(a) + k) % 512];
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic op(input bit rd, input bit wr, input logic [8:0] a,
                      input logic [31:0] d, input logic [2:0] f3,
                      input bit abort);
        int n;
        int off;
        bit legal;
        bit splt;
        logic [31:0] v;
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2})
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(a[1:0]);
        splt  = legal && (off + n > 4);
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        wd       = d;
        func3    = f3;
        @(posedge clk);
        #1;
        e_busy  = 1'b0;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_chkd  = 1'b0;
        if (rd | wr) begin
            if (!legal) begin
                e_err = 1'b1;
            end else begin
                v = model_load(a, f3);
                if (wr)
                    for (int k = 0; k < n; k++)
                        if (off + k < 4)
                            ref_mem[(int'(a) + k) % 512] = d[8*k +: 8];
                if (splt) begin
                    e_busy = 1'b1;
                    if (abort) begin
                        @(negedge clk);
                        reset    = 1'b1;
                        MemRead  = 1'b0;
                        MemWrite = 1'b0;
                        @(posedge clk);
                        #1;
                        e_busy = 1'b0;
                        e_chkd = 1'b1;
                        e_data = 32'h0;
                    end else begin
                        MemRead  = 1'($urandom);
                        MemWrite = 1'($urandom);
                        addr     = 9'($urandom);
                        wd       = $urandom;
                        func3    = 3'($urandom);
                        @(posedge clk);
                        #1;
                        e_busy = 1'b0;
                        if (wr)
                            for (int k = 0; k < n; k++)
                                if (off + k >= 4)
                                    ref_mem[(int'(a) + k) % 512] =
                                        d[8*k +: 8];
                    end
                end
                if (!wr && !(splt && abort)) begin
                    e_valid = 1'b1;
                    e_data  = v;
                    e_chkd  = 1'b1;
                end
            end
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic pin(input string name, input logic [31:0] lit);
        chk(name, last_rd, lit);
        chk("model", e_data, lit);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        reset    = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        addr     = '0;
        wd       = '0;
        func3    = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        e_chkd = 1'b1;
        e_data = 32'h0;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;

        for (int w = 0; w < 128; w++)
            op(0, 1, 9'(w * 4), 32'h0, 3'd2, 0);

        op(0, 1, 9'h010, 32'hDEADBEEF, 3'd2, 0);
        op(1, 0, 9'h010, 32'h0, 3'd2, 0);
        pin("lw_010", 32'hDEADBEEF);
        op(0, 1, 9'h013, 32'h000000A5, 3'd0, 0);
        op(1, 0, 9'h013, 32'h0, 3'd0, 0);
        pin("lb_013", 32'hFFFFFFA5);
        op(1, 0, 9'h013, 32'h0, 3'd4, 0);
        pin("lbu_013", 32'h000000A5);
        op(1, 0, 9'h010, 32'h0, 3'd2, 0);
        pin("lw_010_sb", 32'hA5ADBEEF);

        op(0, 1, 9'h00E, 32'h11223344, 3'd2, 0);
        op(1, 0, 9'h00E, 32'h0, 3'd5, 0);
        pin("lhu_00e", 32'h00003344);
        op(1, 0, 9'h010, 32'h0, 3'd5, 0);
        pin("lhu_010", 32'h00001122);
        op(1, 0, 9'h00E, 32'h0, 3'd2, 0);
        pin("lw_00e_split", 32'h11223344);

        op(0, 1, 9'h1FF, 32'h00000080, 3'd0, 0);
        op(0, 1, 9'h000, 32'h0000007F, 3'd0, 0);
        op(1, 0, 9'h1FF, 32'h0, 3'd1, 0);
        pin("lh_wrap", 32'h00007F80);
        op(1, 0, 9'h1FF, 32'h0, 3'd5, 0);
        pin("lhu_wrap", 32'h00007F80);

        op(1, 0, 9'h010, 32'h0, 3'd3, 0);
        op(0, 1, 9'h010, 32'hFFFFFFFF, 3'd4, 0);
        op(1, 0, 9'h010, 32'h0, 3'd2, 0);
        pin("lw_after_illegal", 32'hA5AD1122);

        op(0, 1, 9'h00C, 32'h0, 3'd2, 0);
        op(0, 1, 9'h010, 32'h0, 3'd2, 0);
        op(0, 1, 9'h00E, 32'hAABBCCDD, 3'd2, 1);
        op(0, 0, 9'h000, 32'h0, 3'd0, 0);
        op(1, 0, 9'h00C, 32'h0, 3'd2, 0);
        pin("lw_00c_abort", 32'hCCDD0000);
        op(1, 0, 9'h010, 32'h0, 3'd2, 0);
        pin("lw_010_abort", 32'h00000000);

        for (int i = 0; i < 600; i++) begin
            bit          r;
            bit          w;
            logic [2:0]  f;
            logic [8:0]  a;
            r = 1'($urandom);
            w = 1'($urandom);
            f = ($urandom_range(0, 7) == 0) ? 3'($urandom)
                : (w ? 3'($urandom_range(0, 2))
                     : 3'(($urandom_range(0, 4) + 3'd0)));
            if (!w && f == 3'd3) f = 3'd4;
            a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 15))
                                            : 9'($urandom);
            op(r, w, a, $urandom, f, 0);
        end
        op(0, 0, 9'h000, 32'h0, 3'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
